// File: rtl/fadd_pkg.sv
// ============================================================================
// Module  : fadd_pkg
// Brief   : Shared types and constants for the sequential float adder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fadd_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [31:0]      POS_INF = 32'h7F800000;
    localparam logic [31:0]      QNAN    = 32'h7FC00000;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_EXP   = 3'd1;
    localparam logic [2:0] ST_ALIGN = 3'd2;
    localparam logic [2:0] ST_ADD   = 3'd3;
    localparam logic [2:0] ST_NORM  = 3'd4;
    localparam logic [2:0] ST_PACK  = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_EXP   = ST_EXP,
        S_ALIGN = ST_ALIGN,
        S_ADD   = ST_ADD,
        S_NORM  = ST_NORM,
        S_PACK  = ST_PACK,
        S_DONE  = ST_DONE
    } state_t;

    typedef struct packed {
        logic a_max;
        logic b_max;
        logic a_zero;
        logic b_zero;
    } spec_flags_t;

endpackage

`default_nettype wire

// File: rtl/fadd_exp_cmp.sv
// ============================================================================
// Module  : fadd_exp_cmp
// Brief   : Combinational exponent compare and magnitude ordering of A/B.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fadd_exp_cmp
    import fadd_pkg::*;
(
    input  logic [EXP_W+MAN_W-1:0] a_mag,
    input  logic [EXP_W+MAN_W-1:0] b_mag,
    output logic [EXP_W-1:0]       d,
    output logic                   swap,
    output spec_flags_t            spec_flags
);

    logic [EXP_W-1:0]       w_ea;
    logic [EXP_W-1:0]       w_eb;
    logic [EXP_W+MAN_W-1:0] w_key_a;
    logic [EXP_W+MAN_W-1:0] w_key_b;

    assign w_ea = a_mag[EXP_W+MAN_W-1:MAN_W];
    assign w_eb = b_mag[EXP_W+MAN_W-1:MAN_W];

    assign spec_flags.a_max  = (w_ea == EXP_MAX);
    assign spec_flags.b_max  = (w_eb == EXP_MAX);
    assign spec_flags.a_zero = (w_ea == '0);
    assign spec_flags.b_zero = (w_eb == '0);

    // Flushed denormals must order as zero, so their mantissa is masked off.
    assign w_key_a = spec_flags.a_zero ? '0 : a_mag;
    assign w_key_b = spec_flags.b_zero ? '0 : b_mag;

    assign swap = (w_key_b > w_key_a);
    assign d    = swap ? (w_eb - w_ea) : (w_ea - w_eb);

endmodule

`default_nettype wire

// File: rtl/fadd_seq_ctrl.sv
// ============================================================================
// Module  : fadd_seq_ctrl
// Brief   : Multi-cycle single-precision adder sequencer with valid/ready I/O.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fadd_seq_ctrl #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result
);

    import fadd_pkg::*;

    localparam int               c_w       = EXP_W + MAN_W + 1;
    localparam int               c_sb      = EXP_W + MAN_W;
    localparam int               c_sig_w   = MAN_W + 1;
    localparam logic [EXP_W-1:0] c_exp_one = EXP_W'(1);
    localparam logic [EXP_W-1:0] c_sig_w_e = EXP_W'(c_sig_w);

    state_t r_state;
    state_t w_state_nxt;

    logic [c_w-1:0]     r_a;
    logic [c_w-1:0]     r_b;
    logic [c_w-1:0]     r_result;
    logic [c_w-1:0]     r_spec_res;
    logic [c_w-1:0]     w_spec_res;
    logic [c_w-1:0]     w_pack;
    logic [EXP_W-1:0]   w_d;
    logic [EXP_W-1:0]   r_d;
    logic [EXP_W-1:0]   r_e;
    logic               w_swap;
    logic               r_swap;
    logic               r_lz;
    logic               r_sz;
    logic               r_special;
    logic               r_zero;
    logic               r_sign;
    logic               r_out_valid;
    logic               w_special;
    logic               w_norm_done;
    spec_flags_t        w_flags;

    logic               w_l_sign;
    logic [EXP_W-1:0]   w_l_exp;
    logic [MAN_W-1:0]   w_l_man;
    logic               w_s_sign;
    logic [MAN_W-1:0]   w_s_man;
    logic [c_sig_w-1:0] w_s_sig;
    logic [c_sig_w-1:0] r_ml;
    logic [c_sig_w-1:0] r_ms;
    logic [c_sig_w:0]   r_m;

    fadd_exp_cmp u_exp_cmp (
        .a_mag      (r_a[c_sb-1:0]),
        .b_mag      (r_b[c_sb-1:0]),
        .d          (w_d),
        .swap       (w_swap),
        .spec_flags (w_flags)
    );

    assign w_special = w_flags.a_max | w_flags.b_max;

    always_comb begin
        w_spec_res = {r_b[c_sb], POS_INF[c_sb-1:0]};
        if (w_flags.a_max && w_flags.b_max && (r_a[c_sb] != r_b[c_sb])) begin
            w_spec_res = QNAN;
        end else if (w_flags.a_max) begin
            w_spec_res = {r_a[c_sb], POS_INF[c_sb-1:0]};
        end
    end

    // L/S views are only meaningful once r_swap has been captured in EXP.
    assign w_l_sign = r_swap ? r_b[c_sb]              : r_a[c_sb];
    assign w_l_exp  = r_swap ? r_b[c_sb-1:MAN_W]      : r_a[c_sb-1:MAN_W];
    assign w_l_man  = r_swap ? r_b[MAN_W-1:0]         : r_a[MAN_W-1:0];
    assign w_s_sign = r_swap ? r_a[c_sb]              : r_b[c_sb];
    assign w_s_man  = r_swap ? r_a[MAN_W-1:0]         : r_b[MAN_W-1:0];
    assign w_s_sig  = {1'b1, w_s_man} >> r_d;

    assign w_norm_done = r_m[c_sig_w] | r_m[c_sig_w-1] | (r_m == '0) | (r_e == c_exp_one);

    always_comb begin
        if (r_special) begin
            w_pack = r_spec_res;
        end else if (r_zero) begin
            w_pack = '0;
        end else if (r_e == EXP_MAX) begin
            w_pack = {r_sign, EXP_MAX, {MAN_W{1'b0}}};
        end else begin
            w_pack = {r_sign, r_e, r_m[MAN_W-1:0]};
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = S_EXP;
            end
            S_EXP:   w_state_nxt = w_special ? S_PACK : S_ALIGN;
            S_ALIGN: w_state_nxt = S_ADD;
            S_ADD:   w_state_nxt = S_NORM;
            S_NORM:  if (w_norm_done) w_state_nxt = S_PACK;
            S_PACK:  w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_a         <= '0;
            r_b         <= '0;
            r_d         <= '0;
            r_swap      <= 1'b0;
            r_lz        <= 1'b0;
            r_sz        <= 1'b0;
            r_special   <= 1'b0;
            r_spec_res  <= '0;
            r_ml        <= '0;
            r_ms        <= '0;
            r_m         <= '0;
            r_e         <= '0;
            r_sign      <= 1'b0;
            r_zero      <= 1'b0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a       <= a;
                        r_b       <= b;
                        r_special <= 1'b0;
                        r_zero    <= 1'b0;
                    end
                end
                S_EXP: begin
                    r_d        <= w_d;
                    r_swap     <= w_swap;
                    r_lz       <= w_swap ? w_flags.b_zero : w_flags.a_zero;
                    r_sz       <= w_swap ? w_flags.a_zero : w_flags.b_zero;
                    r_special  <= w_special;
                    r_spec_res <= w_spec_res;
                end
                S_ALIGN: begin
                    r_ml <= r_lz ? '0 : {1'b1, w_l_man};
                    r_ms <= (r_sz || (r_d >= c_sig_w_e)) ? '0 : w_s_sig;
                end
                S_ADD: begin
                    r_m    <= (w_l_sign == w_s_sign) ? ({1'b0, r_ml} + {1'b0, r_ms})
                                                     : ({1'b0, r_ml} - {1'b0, r_ms});
                    r_e    <= w_l_exp;
                    r_sign <= w_l_sign;
                end
                S_NORM: begin
                    if (r_m[c_sig_w]) begin
                        r_m <= {1'b0, r_m[c_sig_w:1]};
                        r_e <= r_e + c_exp_one;
                    end else if (r_m[c_sig_w-1]) begin
                        r_m <= r_m;
                    end else if (r_m == '0) begin
                        r_zero <= 1'b1;
                    end else begin
                        r_m <= {r_m[c_sig_w-1:0], 1'b0};
                        r_e <= r_e - c_exp_one;
                        // Exponent underflow while normalising flushes to zero.
                        if (r_e == c_exp_one) r_zero <= 1'b1;
                    end
                end
                S_PACK: begin
                    r_result    <= w_pack;
                    r_out_valid <= 1'b1;
                end
                S_DONE: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;

endmodule

`default_nettype wire

// File: tb/tb_fadd_seq_ctrl.sv
// ============================================================================
// Module  : tb_fadd_seq_ctrl
// Brief   : Scoreboard bench for fadd_seq_ctrl with directed vectors.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fadd_seq_ctrl;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] val;
        int          lat;
        int          acc;
        int          id;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fadd_seq_ctrl dut (
        .clk       (clk),
        .res       (res),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    localparam int NV = 16;
    // Latency -1 marks vectors whose latency is not checked.
    logic [31:0] tv_a   [NV] = '{32'h3F800000, 32'h3FC00000, 32'h3F800000, 32'h40400000,
                                 32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                                 32'h7F7FFFFF, 32'h00000001, 32'h00000000, 32'h00800000,
                                 32'h7F800000, 32'hBF800000, 32'h7F800000, 32'hC0000000};
    logic [31:0] tv_b   [NV] = '{32'h3F800000, 32'hBF800000, 32'h30800000, 32'hC0400000,
                                 32'h40400000, 32'h34000000, 32'h33800000, 32'hBF7FFFFF,
                                 32'h7F7FFFFF, 32'h3F800000, 32'h00000000, 32'h80C00000,
                                 32'h3F800000, 32'hFF800000, 32'hFF800000, 32'h3F800000};
    logic [31:0] tv_exp [NV] = '{32'h40000000, 32'h3F000000, 32'h3F800000, 32'h00000000,
                                 32'h40A00000, 32'h3F800001, 32'h3F800000, 32'h34000000,
                                 32'h7F800000, 32'h3F800000, 32'h00000000, 32'h00000000,
                                 32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'hBF800000};
    int          tv_lat [NV] = '{5, 6, 5, 5, 5, 5, 5, 28, 5, 5, 5, -1, -1, -1, -1, 6};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Monitor: compares each newly presented result against the scoreboard head.
    logic mon_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (res) begin
            mon_prev = 1'b0;
        end else begin
            if (out_valid && !mon_prev) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: result %h presented, none expected", result);
                end else begin
                    e = sb.pop_front();
                    n_vec++;
                    if (result !== e.val) begin
                        n_err++;
                        $display("FAIL vec%0d_result: got %h, expected %h", e.id, result, e.val);
                    end
                    if (e.lat >= 0) begin
                        n_vec++;
                        if (cyc - e.acc != e.lat) begin
                            n_err++;
                            $display("FAIL vec%0d_latency: got %0d, expected %0d",
                                     e.id, cyc - e.acc, e.lat);
                        end
                    end
                end
            end
            mon_prev = out_valid;
        end
    end

    task automatic push_exp(input logic [31:0] v, input int lat, input int id);
        exp_t e;
        e.val = v;
        e.lat = lat;
        e.acc = cyc;
        e.id  = id;
        sb.push_back(e);
    endtask

    task automatic wait_handshake(input int id);
        int t = 0;
        @(negedge clk);
        while (!(out_valid && out_ready) && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (!(out_valid && out_ready)) begin
            n_vec++;
            n_err++;
            $display("FAIL vec%0d_timeout: got no handshake, expected one within 60 cycles", id);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] ve, input int lat, input int id);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL vec%0d_ready_timeout: got in_ready 0, expected 1", id);
        end else begin
            a = va;
            b = vb;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            push_exp(ve, lat, id);
            wait_handshake(id);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        #2;
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_result", result, 32'h0);
        @(negedge clk);
        res = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_op(tv_a[i], tv_b[i], tv_exp[i], tv_lat[i], i);
        end

        // Backpressure: result held while out_ready is low, no second accept.
        @(negedge clk);
        out_ready = 1'b0;
        a = 32'h3F800000;
        b = 32'h3F800000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        push_exp(32'h40000000, 5, 100);
        a = 32'h40400000;
        b = 32'h40400000;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            check("bp_result", result, 32'h40000000);
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
        check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (8) @(negedge clk);

        // Abort in NORM: reset mid-operation discards the op.
        @(negedge clk);
        a = 32'h3FC00000;
        b = 32'hBF800000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("abort_busy_in_ready", {31'b0, in_ready}, 32'd0);
        res = 1'b1;
        #1;
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_in_ready", {31'b0, in_ready}, 32'd1);
        check("abort_result", result, 32'h0);
        @(negedge clk);
        res = 1'b0;
        repeat (12) @(negedge clk);

        run_op(32'h7F800000, 32'hFF800000, 32'h7FC00000, -1, 200);
        run_op(32'h3FC00000, 32'hBF800000, 32'h3F000000, 6, 201);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
